// File: rtl/ff_game_pkg.sv
// Shared game types and screen geometry for the round/health controller.
package ff_game_pkg;

  localparam int unsigned HEALTH_W    = 7;
  localparam int unsigned COORD_W     = 10;
  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned BAR_X_LEFT  = 20;
  localparam int unsigned BAR_X_RIGHT = 620;
  localparam int unsigned BAR_H       = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIGHT = 2'd1,
    ST_OVER  = 2'd2
  } game_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_DRAW = 2'd3
  } winner_t;

endpackage

// File: rtl/fighter_health.sv
// One fighter's health: hit edge detect, saturating damage, invulnerability window.
module fighter_health
  import ff_game_pkg::*;
#(
  parameter int unsigned MAX_HEALTH    = 100,
  parameter int unsigned DAMAGE        = 10,
  parameter int unsigned INVULN_FRAMES = 30
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_tick,
  input  logic                enable,
  input  logic                reload,
  input  logic                hit,
  output logic [HEALTH_W-1:0] health
);

  localparam int unsigned INV_W = $clog2(INVULN_FRAMES + 2);

  logic             hit_q;
  logic [INV_W-1:0] invuln;
  logic             accept_c;

  // Rising edge of the hit level, taken only while vulnerable and fighting
  assign accept_c = enable && !reload && hit && !hit_q && (invuln == '0);

  // Hit history always tracks the input so idle-time edges are consumed
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) hit_q <= 1'b0;
    else          hit_q <= hit;
  end

  // Health and invulnerability counter; reload wins over a coincident hit
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      health <= HEALTH_W'(MAX_HEALTH);
      invuln <= '0;
    end else if (reload) begin
      health <= HEALTH_W'(MAX_HEALTH);
      invuln <= '0;
    end else if (accept_c) begin
      health <= (health > HEALTH_W'(DAMAGE)) ? health - HEALTH_W'(DAMAGE) : '0;
      invuln <= INV_W'(INVULN_FRAMES);
    end else if (frame_tick && (invuln != '0)) begin
      invuln <= invuln - INV_W'(1);
    end
  end

endmodule

// File: rtl/health_round_ctrl.sv
// Round controller: frame tick sync, round timer, winner decision, health bars.
module health_round_ctrl
  import ff_game_pkg::*;
#(
  parameter int unsigned MAX_HEALTH     = 100,
  parameter int unsigned DAMAGE         = 10,
  parameter int unsigned INVULN_FRAMES  = 30,
  parameter int unsigned ROUND_SECONDS  = 99,
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned BAR_Y          = 20
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_clk,
  input  logic                start,
  input  logic                restart,
  input  logic                hit_on_p2,
  input  logic                hit_on_p1,
  input  logic [COORD_W-1:0]  DrawX,
  input  logic [COORD_W-1:0]  DrawY,
  output logic [HEALTH_W-1:0] p1_health,
  output logic [HEALTH_W-1:0] p2_health,
  output logic [6:0]          round_timer,
  output logic [1:0]          game_state,
  output logic [1:0]          winner,
  output logic                freeze,
  output logic                is_bar1,
  output logic                is_bar2
);

  localparam int unsigned FPS_W = $clog2(FRAMES_PER_SEC + 1);

  game_state_t      state;
  winner_t          win;
  logic [FPS_W-1:0] fps_cnt;
  logic             fs1, fs2, fs3, frame_tick;
  logic             enable_c, reload_c;

  assign enable_c   = (state == ST_FIGHT);
  assign reload_c   = restart || ((state == ST_IDLE) && start);
  assign game_state = state;
  assign winner     = win;
  assign freeze     = (state != ST_FIGHT);

  // Bring vsync into the Clk domain and turn its rising edge into a one-cycle tick
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs1        <= 1'b0;
      fs2        <= 1'b0;
      fs3        <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      fs1        <= frame_clk;
      fs2        <= fs1;
      fs3        <= fs2;
      frame_tick <= fs2 && !fs3;
    end
  end

  fighter_health #(
    .MAX_HEALTH   (MAX_HEALTH),
    .DAMAGE       (DAMAGE),
    .INVULN_FRAMES(INVULN_FRAMES)
  ) u_p1 (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_tick(frame_tick),
    .enable    (enable_c),
    .reload    (reload_c),
    .hit       (hit_on_p1),
    .health    (p1_health)
  );

  fighter_health #(
    .MAX_HEALTH   (MAX_HEALTH),
    .DAMAGE       (DAMAGE),
    .INVULN_FRAMES(INVULN_FRAMES)
  ) u_p2 (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_tick(frame_tick),
    .enable    (enable_c),
    .reload    (reload_c),
    .hit       (hit_on_p2),
    .health    (p2_health)
  );

  // Round FSM with timer and winner; restart overrides everything
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      win         <= WIN_NONE;
      round_timer <= 7'(ROUND_SECONDS);
      fps_cnt     <= '0;
    end else if (restart) begin
      state       <= ST_IDLE;
      win         <= WIN_NONE;
      round_timer <= 7'(ROUND_SECONDS);
      fps_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_FIGHT;
            win         <= WIN_NONE;
            round_timer <= 7'(ROUND_SECONDS);
            fps_cnt     <= '0;
          end
        end
        ST_FIGHT: begin
          if ((p1_health == '0) || (p2_health == '0) || (round_timer == '0)) begin
            state <= ST_OVER;
            if ((p1_health == '0) && (p2_health == '0)) win <= WIN_DRAW;
            else if (p2_health == '0)                   win <= WIN_P1;
            else if (p1_health == '0)                   win <= WIN_P2;
            else if (p1_health > p2_health)             win <= WIN_P1;
            else if (p2_health > p1_health)             win <= WIN_P2;
            else                                        win <= WIN_DRAW;
          end else if (frame_tick) begin
            if (fps_cnt == FPS_W'(FRAMES_PER_SEC - 1)) begin
              fps_cnt <= '0;
              if (round_timer != '0) round_timer <= round_timer - 7'd1;
            end else begin
              fps_cnt <= fps_cnt + FPS_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  logic [10:0] x11, y11, bar1_end, bar2_start;
  logic        in_rows_c;

  // Health bar pixel flags at 11 bits so an empty bar cannot wrap
  always_comb begin
    x11        = {1'b0, DrawX};
    y11        = {1'b0, DrawY};
    bar1_end   = 11'(BAR_X_LEFT) + {3'b000, p1_health, 1'b0};
    bar2_start = 11'(BAR_X_RIGHT) - {3'b000, p2_health, 1'b0};
    in_rows_c  = (y11 >= 11'(BAR_Y)) && (y11 < 11'(BAR_Y) + 11'(BAR_H));
    is_bar1    = in_rows_c && (x11 >= 11'(BAR_X_LEFT)) && (x11 < bar1_end);
    is_bar2    = in_rows_c && (x11 >= bar2_start) && (x11 < 11'(BAR_X_RIGHT));
  end

endmodule

// File: tb/tb_health_round_ctrl.sv
// Directed bench for health_round_ctrl: default instance plus a short-round instance.
module tb_health_round_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       start = 1'b0, restart = 1'b0, hit_on_p1 = 1'b0, hit_on_p2 = 1'b0;
  logic       start_t = 1'b0, hit_t = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;

  logic [6:0] p1_health, p2_health, round_timer;
  logic [1:0] game_state, winner;
  logic       freeze, is_bar1, is_bar2;

  logic [6:0] t_p1, t_p2, t_timer;
  logic [1:0] t_state, t_winner;
  logic       t_freeze, t_bar1, t_bar2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 Clk = ~Clk;

  health_round_ctrl u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .start(start), .restart(restart), .hit_on_p2(hit_on_p2), .hit_on_p1(hit_on_p1),
    .DrawX(DrawX), .DrawY(DrawY),
    .p1_health(p1_health), .p2_health(p2_health), .round_timer(round_timer),
    .game_state(game_state), .winner(winner), .freeze(freeze),
    .is_bar1(is_bar1), .is_bar2(is_bar2)
  );

  health_round_ctrl #(.ROUND_SECONDS(3), .FRAMES_PER_SEC(2)) u_dut_t (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .start(start_t), .restart(1'b0), .hit_on_p2(hit_t), .hit_on_p1(1'b0),
    .DrawX(DrawX), .DrawY(DrawY),
    .p1_health(t_p1), .p2_health(t_p2), .round_timer(t_timer),
    .game_state(t_state), .winner(t_winner), .freeze(t_freeze),
    .is_bar1(t_bar1), .is_bar2(t_bar2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One full vsync period, long enough for the synchronised tick to land
  task automatic tick();
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  // Single-cycle hit pulse on the main instance; outputs settled on return
  task automatic pulse(input logic p1, input logic p2);
    hit_on_p1 = p1;
    hit_on_p2 = p2;
    @(negedge Clk);
    hit_on_p1 = 1'b0;
    hit_on_p2 = 1'b0;
  endtask

  task automatic start_round();
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge Clk);
    restart = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    check("rst_state",  32'(game_state), 0);
    check("rst_freeze", 32'(freeze), 1);
    check("rst_p1",     32'(p1_health), 100);
    check("rst_p2",     32'(p2_health), 100);
    check("rst_timer",  32'(round_timer), 99);
    check("rst_winner", 32'(winner), 0);
    check("rst_t_timer", 32'(t_timer), 3);

    // Short-round instance: timer expiry decides on health
    start_t = 1'b1;
    @(negedge Clk);
    start_t = 1'b0;
    check("t_fight", 32'(t_state), 1);
    hit_t = 1'b1;
    @(negedge Clk);
    hit_t = 1'b0;
    check("t_p2_hit", 32'(t_p2), 90);
    repeat (5) tick();
    check("t_timer_5", 32'(t_timer), 1);
    check("t_state_5", 32'(t_state), 1);
    tick();
    check("t_timer_6", 32'(t_timer), 0);
    check("t_state_6", 32'(t_state), 2);
    check("t_winner",  32'(t_winner), 1);
    check("t_p1",      32'(t_p1), 100);
    check("main_idle_timer", 32'(round_timer), 99);

    // Main instance: first hit, held level, invulnerability window
    start_round();
    check("fight_state",  32'(game_state), 1);
    check("fight_freeze", 32'(freeze), 0);
    hit_on_p2 = 1'b1;
    @(negedge Clk);
    check("p2_first_hit", 32'(p2_health), 90);
    repeat (4) @(negedge Clk);
    hit_on_p2 = 1'b0;
    @(negedge Clk);
    check("p2_level_held", 32'(p2_health), 90);
    repeat (10) tick();
    pulse(1'b0, 1'b1);
    check("p2_invuln_ignored", 32'(p2_health), 90);
    repeat (20) tick();
    pulse(1'b0, 1'b1);
    check("p2_after_30", 32'(p2_health), 80);

    for (int i = 0; i < 8; i++) begin
      repeat (30) tick();
      pulse(1'b0, 1'b1);
      check("p2_spaced", 32'(p2_health), 32'(70 - 10 * i));
    end
    check("p2_zero_still_fight", 32'(game_state), 1);
    @(negedge Clk);
    check("ko_state",  32'(game_state), 2);
    check("ko_winner", 32'(winner), 1);
    check("ko_freeze", 32'(freeze), 1);
    check("ko_p1",     32'(p1_health), 100);

    do_restart();
    check("restart_state",  32'(game_state), 0);
    check("restart_p2",     32'(p2_health), 100);
    check("restart_winner", 32'(winner), 0);

    // Simultaneous hits down to a double knockout
    start_round();
    for (int i = 0; i < 9; i++) begin
      repeat (30) tick();
      pulse(1'b1, 1'b1);
      check("both_p1", 32'(p1_health), 32'(90 - 10 * i));
      check("both_p2", 32'(p2_health), 32'(90 - 10 * i));
    end
    repeat (30) tick();
    pulse(1'b1, 1'b1);
    check("draw_p1", 32'(p1_health), 0);
    check("draw_p2", 32'(p2_health), 0);
    @(negedge Clk);
    check("draw_state",  32'(game_state), 2);
    check("draw_winner", 32'(winner), 3);
    DrawY = 10'd25;
    DrawX = 10'd20;
    #1 check("bar1_empty", 32'(is_bar1), 0);
    DrawX = 10'd619;
    #1 check("bar2_empty", 32'(is_bar2), 0);

    // Restart beats a coincident hit edge
    do_restart();
    start_round();
    check("fight2_state", 32'(game_state), 1);
    restart   = 1'b1;
    hit_on_p1 = 1'b1;
    @(negedge Clk);
    restart = 1'b0;
    check("rh_state", 32'(game_state), 0);
    check("rh_p1",    32'(p1_health), 100);
    hit_on_p1 = 1'b0;
    @(negedge Clk);
    check("rh_p1_after", 32'(p1_health), 100);

    // Bar edges at full health
    DrawY = 10'd25; DrawX = 10'd219; #1 check("bar1_x219", 32'(is_bar1), 1);
    DrawX = 10'd220; #1 check("bar1_x220", 32'(is_bar1), 0);
    DrawX = 10'd20;  #1 check("bar1_x20",  32'(is_bar1), 1);
    DrawX = 10'd19;  #1 check("bar1_x19",  32'(is_bar1), 0);
    DrawX = 10'd420; #1 check("bar2_x420", 32'(is_bar2), 1);
    DrawX = 10'd419; #1 check("bar2_x419", 32'(is_bar2), 0);
    DrawX = 10'd619; #1 check("bar2_x619", 32'(is_bar2), 1);
    DrawX = 10'd620; #1 check("bar2_x620", 32'(is_bar2), 0);
    DrawX = 10'd100; DrawY = 10'd30; #1 check("bar1_y30", 32'(is_bar1), 0);
    DrawY = 10'd19;  #1 check("bar1_y19", 32'(is_bar1), 0);
    DrawY = 10'd29;  #1 check("bar1_y29", 32'(is_bar1), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/health_round_ctrl.md
Name: health_round_ctrl

Overview:
- Round/health controller sitting directly downstream of the projectile block, beside the player/npc movers.
- Consumes hit indications, keeps both fighters' health and the round timer, and decides the winner.
- Drives a freeze signal back to the movers.
- Produces health-bar pixel flags for the colour mapper from DrawX/DrawY.

Parameters:
- MAX_HEALTH, 100, starting health of each fighter (range 1..127).
- DAMAGE, 10, health removed per accepted hit.
- INVULN_FRAMES, 30, frames after an accepted hit during which further hits on that fighter are ignored.
- ROUND_SECONDS, 99, round length in seconds.
- FRAMES_PER_SEC, 60, frame ticks per timer second.
- BAR_Y, 20, top row of both health bars; bar height is 10 rows.

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset_n  in  1  asynchronous active-low reset
- frame_clk  in  1  VGA vertical sync; asynchronous to game logic, used as frame tick source
- start  in  1  level; begins a round from IDLE
- restart  in  1  level; aborts any round, returns to IDLE
- hit_on_p2  in  1  level, Clk-synchronous; projectile overlapping fighter 2 (NPC)
- hit_on_p1  in  1  level, Clk-synchronous; projectile overlapping fighter 1 (player)
- DrawX, DrawY  in  10 each  current pixel coordinates
- p1_health, p2_health  out  7 each  current health
- round_timer  out  7  seconds remaining
- game_state  out  2  IDLE=0, FIGHT=1, OVER=2
- winner  out  2  NONE=0, P1=1, P2=2, DRAW=3
- freeze  out  1  high whenever game_state != FIGHT
- is_bar1, is_bar2  out  1 each  pixel belongs to fighter 1 / fighter 2 health bar

Behaviour:
- Reset (Reset_n low, async) values:
  - healths = MAX_HEALTH, round_timer = ROUND_SECONDS
  - game_state = IDLE, winner = NONE, freeze = 1
  - invuln counters = 0, frame-per-second counter = 0
  - frame sync flops = 0
- Frame tick:
  - frame_clk passes through a 2-flop synchroniser, then rising-edge detection.
  - Result is a one-Clk-cycle pulse, 3 Clk cycles after the edge at the input.
- Hit acceptance:
  - Only rising edges of each hit input count (a registered previous value is kept).
  - A hit is accepted only in FIGHT and only while that fighter's invuln counter is 0.
  - On acceptance, health becomes max(health - DAMAGE, 0) on the next Clk edge; invuln counter loads INVULN_FRAMES.
  - Invuln counter decrements by 1 per frame tick and saturates at 0.
- Timer:
  - In FIGHT, each frame tick increments the fps counter.
  - When the counter reaches FRAMES_PER_SEC-1 and a tick arrives, the counter wraps to 0 and round_timer decrements.
  - round_timer saturates at 0.
- FSM:
  - IDLE -> FIGHT: when start is high and restart is low. Health, timer and counters are reloaded on entry.
  - FIGHT -> OVER: next cycle after any health reaches 0, or after round_timer reaches 0.
  - Winner rules:
    - Only p2 at 0 gives P1.
    - Only p1 at 0 gives P2.
    - Both at 0 in the same cycle (simultaneous accepted hits) gives DRAW.
    - Timer expiry gives the higher health; equal health gives DRAW.
  - OVER holds all values until restart.
  - Any state -> IDLE when restart is high: healths and timer reloaded, winner = NONE. Restart has priority over start and over hits in the same cycle.
- Simultaneous hits on both fighters in one cycle: both accepted and applied independently.
- Hit edges while in IDLE/OVER update the edge register but cause no damage.
- Health bars (combinational from registered health; widths are health*2 pixels):
  - is_bar1 = DrawY in [BAR_Y, BAR_Y+9] and DrawX in [20, 20+2*p1_health-1].
  - is_bar2 = same rows and DrawX in [620-2*p2_health, 619].
  - Health 0 gives an empty bar. Compare at 11 bits to avoid underflow.
- freeze is combinational from game_state.

Decomposition:
- Package ff_game_pkg:
  - game_state_t enum (IDLE, FIGHT, OVER).
  - winner_t enum (NONE, P1, P2, DRAW).
  - Screen constants: width 640, bar x-margins 20/620.
- One sub-module, fighter_health, instantiated twice. It holds:
  - hit edge register
  - health register with saturating subtract
  - invuln counter
  - inputs: frame-tick, enable, reload

Test Plan:
- Reset low then high, no start -> game_state=0, freeze=1, p1/p2_health=100, round_timer=99, winner=0.
- start pulse, then hit_on_p2 high for 5 cycles -> p2_health=90 one cycle after the rising edge, still 90 after the level drops. Second edge 10 frame ticks later is ignored (90); edge after 30 ticks -> 80.
- Ten spaced hit_on_p2 edges (>30 ticks apart) -> p2_health reaches 0, game_state=2 next cycle, winner=1, freeze=1.
- Both hits rising in the same cycle with both healths at 10 -> both 0, winner=3.
- FRAMES_PER_SEC=2, ROUND_SECONDS=3, p1=100, p2=90 -> after 6 ticks round_timer=0, game_state=2, winner=1.
- restart asserted mid-FIGHT in the same cycle as a hit edge -> game_state=0, health 100, no damage applied. DrawX=219, DrawY=25 with p1_health=100 -> is_bar1=1; DrawX=220 -> 0.
